// File: rtl/tree_encoder_copad_pipe_if.sv
// Handshake-free candidate bus for the pipelined copad best-candidate selector.
// Latency: n/a (pure wiring bundle).
// Backpressure: none; master presents one candidate vector per clock, slave returns one result per clock.
//
// Port summary:
//   master: drives in_strobe, cand_vld, cand_pri, cand_data, pri_max; receives the best_* result group.
//   slave : the selector side, receives the candidate vector and drives out_strobe/best_*/n_qual.
interface tree_encoder_copad_pipe_if #(
    parameter int NCAND  = 8,
    parameter int PRI_W  = 10,
    parameter int DATA_W = 10
);
    localparam int IDX_W = $clog2(NCAND);

    logic                      in_strobe;
    logic [NCAND-1:0]          cand_vld;
    logic [NCAND*PRI_W-1:0]    cand_pri;
    logic [NCAND*DATA_W-1:0]   cand_data;
    logic [PRI_W-1:0]          pri_max;

    logic                      out_strobe;
    logic                      best_vld;
    logic [PRI_W-1:0]          best_pri;
    logic [DATA_W-1:0]         best_data;
    logic [IDX_W-1:0]          best_idx;
    logic [IDX_W:0]            n_qual;

    modport master (
        output in_strobe, cand_vld, cand_pri, cand_data, pri_max,
        input  out_strobe, best_vld, best_pri, best_data, best_idx, n_qual
    );

    modport slave (
        input  in_strobe, cand_vld, cand_pri, cand_data, pri_max,
        output out_strobe, best_vld, best_pri, best_data, best_idx, n_qual
    );
endinterface

// File: rtl/tree_encoder_copad_pipe.sv
// Pipelined smallest-priority selector over NCAND candidates with qualifying-candidate count.
// Latency: LEVELS = $clog2(NCAND) clocks from input sample to outputs, one register per tree level.
// Backpressure: none; accepts one vector every clock and never stalls.
//
// Ports: clock, reset (synchronous, active-high); io (slave modport) carries in_strobe, cand_vld,
// cand_pri, cand_data, pri_max in and out_strobe, best_vld, best_pri, best_data, best_idx, n_qual out.
module tree_encoder_copad_pipe #(
    parameter int NCAND  = 8,
    parameter int PRI_W  = 10,
    parameter int DATA_W = 10
) (
    input  logic                     clock,
    input  logic                     reset,
    tree_encoder_copad_pipe_if.slave io
);
    localparam int IDX_W  = $clog2(NCAND);
    localparam int LEVELS = $clog2(NCAND);

    // Leaves: combinational qualification of the raw input vector.
    logic              leaf_q    [NCAND];
    logic [PRI_W-1:0]  leaf_pri  [NCAND];
    logic [DATA_W-1:0] leaf_data [NCAND];
    logic [IDX_W-1:0]  leaf_idx  [NCAND];
    logic [IDX_W:0]    leaf_cnt  [NCAND];

    // Internal tree nodes in heap order: node 1 is the root, node n has children 2n and 2n+1.
    // Children numbered NCAND..2*NCAND-1 are the leaves. Every internal node is a register,
    // so each tree level is exactly one pipeline stage.
    logic              node_q    [1:NCAND-1];
    logic [PRI_W-1:0]  node_pri  [1:NCAND-1];
    logic [DATA_W-1:0] node_data [1:NCAND-1];
    logic [IDX_W-1:0]  node_idx  [1:NCAND-1];
    logic [IDX_W:0]    node_cnt  [1:NCAND-1];

    logic              nxt_q     [1:NCAND-1];
    logic [PRI_W-1:0]  nxt_pri   [1:NCAND-1];
    logic [DATA_W-1:0] nxt_data  [1:NCAND-1];
    logic [IDX_W-1:0]  nxt_idx   [1:NCAND-1];
    logic [IDX_W:0]    nxt_cnt   [1:NCAND-1];

    logic [LEVELS-1:0] stb_pipe;

    always_comb begin
        for (int i = 0; i < NCAND; i++) begin
            leaf_pri[i]  = io.cand_pri[i*PRI_W +: PRI_W];
            leaf_data[i] = io.cand_data[i*DATA_W +: DATA_W];
            // A dropped strobe makes the whole vector non-qualifying, which also zeroes n_qual.
            leaf_q[i]    = io.in_strobe & io.cand_vld[i] & (leaf_pri[i] <= io.pri_max);
            // Each leaf carries its full index; the winner's index rides along with it, so the
            // root index equals the one built up bit-per-level from odd-side wins.
            leaf_idx[i]  = IDX_W'(i);
            leaf_cnt[i]  = {{IDX_W{1'b0}}, leaf_q[i]};
        end
    end

    always_comb begin
        logic              e_q, o_q, o_win;
        logic [PRI_W-1:0]  e_pri, o_pri;
        logic [DATA_W-1:0] e_data, o_data;
        logic [IDX_W-1:0]  e_idx, o_idx;
        logic [IDX_W:0]    e_cnt, o_cnt;

        e_q = 1'b0;  o_q = 1'b0;  o_win = 1'b0;
        e_pri = '0;  o_pri = '0;
        e_data = '0; o_data = '0;
        e_idx = '0;  o_idx = '0;
        e_cnt = '0;  o_cnt = '0;

        for (int n = 1; n < NCAND; n++) begin
            nxt_q[n]    = 1'b0;
            nxt_pri[n]  = '0;
            nxt_data[n] = '0;
            nxt_idx[n]  = '0;
            nxt_cnt[n]  = '0;

            if (2*n >= NCAND) begin
                e_q = leaf_q[2*n-NCAND];     o_q = leaf_q[2*n+1-NCAND];
                e_pri = leaf_pri[2*n-NCAND]; o_pri = leaf_pri[2*n+1-NCAND];
                e_data = leaf_data[2*n-NCAND]; o_data = leaf_data[2*n+1-NCAND];
                e_idx = leaf_idx[2*n-NCAND]; o_idx = leaf_idx[2*n+1-NCAND];
                e_cnt = leaf_cnt[2*n-NCAND]; o_cnt = leaf_cnt[2*n+1-NCAND];
            end else begin
                e_q = node_q[2*n];           o_q = node_q[2*n+1];
                e_pri = node_pri[2*n];       o_pri = node_pri[2*n+1];
                e_data = node_data[2*n];     o_data = node_data[2*n+1];
                e_idx = node_idx[2*n];       o_idx = node_idx[2*n+1];
                e_cnt = node_cnt[2*n];       o_cnt = node_cnt[2*n+1];
            end

            // Odd side needs a strictly smaller priority to beat a qualifying even side, so ties
            // resolve to the lower index. With neither side qualifying the even side passes
            // through, which makes a no-winner result carry candidate 0 values at the root.
            o_win = o_q & (~e_q | (o_pri < e_pri));

            nxt_q[n]    = e_q | o_q;
            nxt_pri[n]  = o_win ? o_pri  : e_pri;
            nxt_data[n] = o_win ? o_data : e_data;
            nxt_idx[n]  = o_win ? o_idx  : e_idx;
            nxt_cnt[n]  = e_cnt + o_cnt;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int n = 1; n < NCAND; n++) begin
                node_q[n]    <= 1'b0;
                node_pri[n]  <= '0;
                node_data[n] <= '0;
                node_idx[n]  <= '0;
                node_cnt[n]  <= '0;
            end
            stb_pipe <= '0;
        end else begin
            for (int n = 1; n < NCAND; n++) begin
                node_q[n]    <= nxt_q[n];
                node_pri[n]  <= nxt_pri[n];
                node_data[n] <= nxt_data[n];
                node_idx[n]  <= nxt_idx[n];
                node_cnt[n]  <= nxt_cnt[n];
            end
            stb_pipe <= LEVELS'({stb_pipe, io.in_strobe});
        end
    end

    assign io.out_strobe = stb_pipe[LEVELS-1];
    assign io.best_vld   = node_q[1];
    assign io.best_pri   = node_pri[1];
    assign io.best_data  = node_data[1];
    assign io.best_idx   = node_idx[1];
    assign io.n_qual     = node_cnt[1];
endmodule

// File: tb/tb_tree_encoder_copad_pipe.sv
// Self-checking bench: directed vectors on an 8-candidate instance, random vectors against a
// plain min-finder model on 2-, 16- and 64-candidate instances.
// Latency and strobe behaviour are checked cycle by cycle.
module tb_tree_encoder_copad_pipe;
    localparam int NR = 300;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    tree_encoder_copad_pipe_if #(.NCAND(8),  .PRI_W(10), .DATA_W(10)) if8  ();
    tree_encoder_copad_pipe_if #(.NCAND(2),  .PRI_W(10), .DATA_W(10)) if2  ();
    tree_encoder_copad_pipe_if #(.NCAND(16), .PRI_W(10), .DATA_W(10)) if16 ();
    tree_encoder_copad_pipe_if #(.NCAND(64), .PRI_W(10), .DATA_W(10)) if64 ();

    tree_encoder_copad_pipe #(.NCAND(8),  .PRI_W(10), .DATA_W(10)) dut8  (.clock(clock), .reset(reset), .io(if8));
    tree_encoder_copad_pipe #(.NCAND(2),  .PRI_W(10), .DATA_W(10)) dut2  (.clock(clock), .reset(reset), .io(if2));
    tree_encoder_copad_pipe #(.NCAND(16), .PRI_W(10), .DATA_W(10)) dut16 (.clock(clock), .reset(reset), .io(if16));
    tree_encoder_copad_pipe #(.NCAND(64), .PRI_W(10), .DATA_W(10)) dut64 (.clock(clock), .reset(reset), .io(if64));

    // Shared random stimulus; smaller instances take the low slices.
    logic         r_s = 1'b0;
    logic [63:0]  r_v = '0;
    logic [639:0] r_p = '0;
    logic [639:0] r_d = '0;
    logic [9:0]   r_m = '0;

    assign if2.in_strobe  = r_s;        assign if16.in_strobe = r_s;         assign if64.in_strobe = r_s;
    assign if2.cand_vld   = r_v[1:0];   assign if16.cand_vld  = r_v[15:0];   assign if64.cand_vld  = r_v;
    assign if2.cand_pri   = r_p[19:0];  assign if16.cand_pri  = r_p[159:0];  assign if64.cand_pri  = r_p;
    assign if2.cand_data  = r_d[19:0];  assign if16.cand_data = r_d[159:0];  assign if64.cand_data = r_d;
    assign if2.pri_max    = r_m;        assign if16.pri_max   = r_m;         assign if64.pri_max   = r_m;

    logic         h_s [NR+8];
    logic [63:0]  h_v [NR+8];
    logic [639:0] h_p [NR+8];
    logic [639:0] h_d [NR+8];
    logic [9:0]   h_m [NR+8];

    // {out_strobe, best_vld, best_pri, best_data, best_idx, n_qual} of the 8-candidate instance
    logic [28:0] got8;
    assign got8 = {if8.out_strobe, if8.best_vld, if8.best_pri, if8.best_data, if8.best_idx, if8.n_qual};

    function automatic logic [28:0] tup(input logic s, input logic v, input int pri, input int data,
                                        input int idx, input int nq);
        return {s, v, 10'(pri), 10'(data), 3'(idx), 4'(nq)};
    endfunction

    function automatic string fmt8(input logic [28:0] t);
        return $sformatf("stb=%b vld=%b pri=%0d data=%0d idx=%0d nq=%0d",
                         t[28], t[27], t[26:17], t[16:7], t[6:4], t[3:0]);
    endfunction

    function automatic logic [79:0] pack8(input int a0, input int a1, input int a2, input int a3,
                                          input int a4, input int a5, input int a6, input int a7);
        return {10'(a7), 10'(a6), 10'(a5), 10'(a4), 10'(a3), 10'(a2), 10'(a1), 10'(a0)};
    endfunction

    function automatic logic [79:0] data8(input int base);
        logic [79:0] d;
        d = '0;
        for (int i = 0; i < 8; i++) d[i*10 +: 10] = 10'(base + i);
        return d;
    endfunction

    // Reference: linear scan for the smallest qualifying priority, first index wins ties.
    function automatic void model(input int n, input logic s, input logic [63:0] v,
                                  input logic [639:0] p, input logic [639:0] d, input logic [9:0] pm,
                                  output logic ev, output int epri, output int edat,
                                  output int eidx, output int ecnt);
        ev = 1'b0; epri = int'(p[9:0]); edat = int'(d[9:0]); eidx = 0; ecnt = 0;
        for (int i = 0; i < n; i++) begin
            if (s && v[i] && (p[i*10 +: 10] <= pm)) begin
                ecnt++;
                if (!ev || int'(p[i*10 +: 10]) < epri) begin
                    ev = 1'b1; epri = int'(p[i*10 +: 10]); edat = int'(d[i*10 +: 10]); eidx = i;
                end
            end
        end
    endfunction

    task automatic tick;
        @(negedge clock);
    endtask

    task automatic drive8(input logic s, input logic [7:0] v, input logic [79:0] p,
                          input logic [79:0] d, input logic [9:0] pm);
        if8.in_strobe = s;
        if8.cand_vld  = v;
        if8.cand_pri  = p;
        if8.cand_data = d;
        if8.pri_max   = pm;
    endtask

    task automatic idle(input int n);
        if8.in_strobe = 1'b0;
        repeat (n) tick();
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if (got8 !== '0) begin
            n_bad++; $display("FAIL reset_n8: got %s, expected all zero", fmt8(got8));
        end
        n_cmp++;
        if ({if2.out_strobe, if2.best_vld, if2.best_pri, if2.best_data, if2.best_idx, if2.n_qual} !== '0) begin
            n_bad++; $display("FAIL reset_n2: outputs not all zero (vld=%b nq=%0d)", if2.best_vld, if2.n_qual);
        end
        n_cmp++;
        if ({if64.out_strobe, if64.best_vld, if64.best_pri, if64.best_data, if64.best_idx, if64.n_qual} !== '0) begin
            n_bad++; $display("FAIL reset_n64: outputs not all zero (vld=%b nq=%0d)", if64.best_vld, if64.n_qual);
        end
        reset = 1'b0;
        idle(4);
    endtask

    task automatic test_basic;
        logic [28:0] exp;
        drive8(1'b1, 8'hFF, pack8(40, 30, 20, 10, 15, 25, 35, 45), data8(100), 10'h3FF);
        tick();
        if8.in_strobe = 1'b0;
        tick();
        n_cmp++;
        if (if8.out_strobe !== 1'b0) begin
            n_bad++; $display("FAIL basic_early: out_strobe=%b two clocks after input, expected 0", if8.out_strobe);
        end
        tick();
        exp = tup(1, 1, 10, 103, 3, 8);
        n_cmp++;
        if (got8 !== exp) begin
            n_bad++; $display("FAIL basic: got %s, expected %s", fmt8(got8), fmt8(exp));
        end
        tick();
        n_cmp++;
        if (if8.out_strobe !== 1'b0) begin
            n_bad++; $display("FAIL basic_late: out_strobe=%b four clocks after input, expected 0", if8.out_strobe);
        end
        idle(2);
    endtask

    task automatic test_ties;
        logic [28:0] exp;
        drive8(1'b1, 8'hFF, pack8(7, 7, 7, 7, 7, 7, 7, 7), data8(100), 10'h3FF);
        tick();
        drive8(1'b1, 8'hFF, pack8(9, 9, 9, 9, 9, 2, 2, 9), data8(100), 10'h3FF);
        tick();
        if8.in_strobe = 1'b0;
        tick();
        exp = tup(1, 1, 7, 100, 0, 8);
        n_cmp++;
        if (got8 !== exp) begin
            n_bad++; $display("FAIL ties_all: got %s, expected %s", fmt8(got8), fmt8(exp));
        end
        tick();
        exp = tup(1, 1, 2, 105, 5, 8);
        n_cmp++;
        if (got8 !== exp) begin
            n_bad++; $display("FAIL ties_pair: got %s, expected %s", fmt8(got8), fmt8(exp));
        end
        idle(3);
    endtask

    task automatic test_qualification;
        logic [28:0] exp;
        drive8(1'b1, 8'b1111_0111, pack8(5, 3, 8, 1, 9, 9, 9, 9), data8(100), 10'd4);
        tick();
        if8.pri_max = 10'd0;
        tick();
        if8.in_strobe = 1'b0;
        tick();
        exp = tup(1, 1, 3, 101, 1, 1);
        n_cmp++;
        if (got8 !== exp) begin
            n_bad++; $display("FAIL qual_limit4: got %s, expected %s", fmt8(got8), fmt8(exp));
        end
        tick();
        exp = tup(1, 0, 5, 100, 0, 0);
        n_cmp++;
        if (got8 !== exp) begin
            n_bad++; $display("FAIL qual_limit0: got %s, expected %s", fmt8(got8), fmt8(exp));
        end
        idle(3);
    endtask

    task automatic test_pri_max_ones;
        logic [28:0] exp;
        drive8(1'b1, 8'b1010_0000, pack8(0, 0, 0, 0, 0, 1023, 0, 1000), data8(100), 10'h3FF);
        tick();
        idle(2);
        exp = tup(1, 1, 1000, 107, 7, 2);
        n_cmp++;
        if (got8 !== exp) begin
            n_bad++; $display("FAIL pri_max_ones: got %s, expected %s", fmt8(got8), fmt8(exp));
        end
        idle(3);
    endtask

    task automatic test_no_strobe;
        logic [28:0] exp;
        drive8(1'b0, 8'hFF, pack8(40, 30, 20, 10, 15, 25, 35, 45), data8(100), 10'h3FF);
        repeat (3) tick();
        exp = tup(0, 0, 40, 100, 0, 0);
        n_cmp++;
        if (got8 !== exp) begin
            n_bad++; $display("FAIL no_strobe: got %s, expected %s", fmt8(got8), fmt8(exp));
        end
        idle(2);
    endtask

    task automatic test_back_to_back;
        int          wins [6];
        logic [79:0] p;
        logic [28:0] exp;
        wins = '{7, 0, 4, 2, 6, 1};
        for (int c = 0; c < 9; c++) begin
            if (c < 3) begin
                n_cmp++;
                if (if8.out_strobe !== 1'b0) begin
                    n_bad++; $display("FAIL b2b_pre cyc %0d: out_strobe=%b, expected 0", c, if8.out_strobe);
                end
            end else begin
                exp = tup(1, 1, 10 + (c-3), 100 + 8*(c-3) + wins[c-3], wins[c-3], 8);
                n_cmp++;
                if (got8 !== exp) begin
                    n_bad++; $display("FAIL b2b vec %0d: got %s, expected %s", c-3, fmt8(got8), fmt8(exp));
                end
            end
            if (c < 6) begin
                for (int i = 0; i < 8; i++) p[i*10 +: 10] = (i == wins[c]) ? 10'(10 + c) : 10'd50;
                drive8(1'b1, 8'hFF, p, data8(100 + 8*c), 10'h3FF);
            end else begin
                if8.in_strobe = 1'b0;
            end
            tick();
        end
        idle(3);
    endtask

    task automatic test_reset_mid;
        logic [28:0] exp;
        drive8(1'b1, 8'hFF, pack8(40, 30, 20, 10, 15, 25, 35, 45), data8(100), 10'h3FF);
        tick();
        drive8(1'b1, 8'hFF, pack8(7, 7, 7, 7, 7, 7, 7, 7), data8(100), 10'h3FF);
        tick();
        reset = 1'b1;
        if8.in_strobe = 1'b0;
        for (int c = 3; c < 7; c++) begin
            tick();
            n_cmp++;
            if (got8 !== '0) begin
                n_bad++; $display("FAIL reset_mid cyc %0d: got %s, expected all zero", c, fmt8(got8));
            end
            if (c == 4) begin
                reset = 1'b0;
                drive8(1'b1, 8'hFF, pack8(40, 30, 20, 10, 15, 25, 35, 45), data8(100), 10'h3FF);
            end else begin
                if8.in_strobe = 1'b0;
            end
        end
        tick();
        exp = tup(1, 1, 10, 103, 3, 8);
        n_cmp++;
        if (got8 !== exp) begin
            n_bad++; $display("FAIL reset_mid_resume: got %s, expected %s", fmt8(got8), fmt8(exp));
        end
        idle(3);
    endtask

    task automatic test_random_sizes;
        logic ev;
        int   epri, edat, eidx, ecnt, k;
        for (int c = 0; c < NR + 8; c++) begin
            if (c >= 1) begin
                k = c - 1;
                model(2, h_s[k], h_v[k], h_p[k], h_d[k], h_m[k], ev, epri, edat, eidx, ecnt);
                n_cmp++;
                if (if2.out_strobe !== h_s[k] || if2.best_vld !== ev || if2.best_pri !== 10'(epri) ||
                    if2.best_data !== 10'(edat) || if2.best_idx !== 1'(eidx) || if2.n_qual !== 2'(ecnt)) begin
                    n_bad++;
                    $display("FAIL rand_n2 vec %0d: got stb=%b vld=%b pri=%0d data=%0d idx=%0d nq=%0d, expected stb=%b vld=%b pri=%0d data=%0d idx=%0d nq=%0d",
                             k, if2.out_strobe, if2.best_vld, if2.best_pri, if2.best_data, if2.best_idx, if2.n_qual,
                             h_s[k], ev, epri, edat, eidx, ecnt);
                end
            end
            if (c >= 4) begin
                k = c - 4;
                model(16, h_s[k], h_v[k], h_p[k], h_d[k], h_m[k], ev, epri, edat, eidx, ecnt);
                n_cmp++;
                if (if16.out_strobe !== h_s[k] || if16.best_vld !== ev || if16.best_pri !== 10'(epri) ||
                    if16.best_data !== 10'(edat) || if16.best_idx !== 4'(eidx) || if16.n_qual !== 5'(ecnt)) begin
                    n_bad++;
                    $display("FAIL rand_n16 vec %0d: got stb=%b vld=%b pri=%0d data=%0d idx=%0d nq=%0d, expected stb=%b vld=%b pri=%0d data=%0d idx=%0d nq=%0d",
                             k, if16.out_strobe, if16.best_vld, if16.best_pri, if16.best_data, if16.best_idx, if16.n_qual,
                             h_s[k], ev, epri, edat, eidx, ecnt);
                end
            end
            if (c >= 6) begin
                k = c - 6;
                model(64, h_s[k], h_v[k], h_p[k], h_d[k], h_m[k], ev, epri, edat, eidx, ecnt);
                n_cmp++;
                if (if64.out_strobe !== h_s[k] || if64.best_vld !== ev || if64.best_pri !== 10'(epri) ||
                    if64.best_data !== 10'(edat) || if64.best_idx !== 6'(eidx) || if64.n_qual !== 7'(ecnt)) begin
                    n_bad++;
                    $display("FAIL rand_n64 vec %0d: got stb=%b vld=%b pri=%0d data=%0d idx=%0d nq=%0d, expected stb=%b vld=%b pri=%0d data=%0d idx=%0d nq=%0d",
                             k, if64.out_strobe, if64.best_vld, if64.best_pri, if64.best_data, if64.best_idx, if64.n_qual,
                             h_s[k], ev, epri, edat, eidx, ecnt);
                end
            end
            // Narrow priority range so ties and threshold hits are common.
            h_s[c] = (c < NR) && ($urandom_range(0, 7) != 0);
            h_v[c] = {$urandom, $urandom};
            for (int i = 0; i < 64; i++) begin
                h_p[c][i*10 +: 10] = ($urandom_range(0, 9) == 0) ? 10'($urandom) : 10'($urandom_range(0, 15));
                h_d[c][i*10 +: 10] = 10'($urandom);
            end
            h_m[c] = ($urandom_range(0, 3) == 0) ? 10'h3FF : 10'($urandom_range(0, 15));
            r_s = h_s[c]; r_v = h_v[c]; r_p = h_p[c]; r_d = h_d[c]; r_m = h_m[c];
            tick();
        end
    endtask

    initial begin
        drive8(1'b0, '0, '0, '0, '0);
        test_reset();
        test_basic();
        test_ties();
        test_qualification();
        test_pri_max_ones();
        test_no_strobe();
        test_back_to_back();
        test_reset_mid();
        test_random_sizes();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
